sync_fifo_param: RTL and testbench

//   Parametrised single-clock FIFO, successor to the fixed 8x64 FIFO. Adds configurable width/depth,

---
 rtl/sync_fifo_param.sv | 96 +++++++++
 tb/tb_sync_fifo_param.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with almost-full/almost-empty thresholds, standard or FWFT read,
// full-with-read pass-through and sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 64,
  parameter int AF_THRESH = 56,
  parameter int AE_THRESH = 8,
  parameter bit FWFT      = 1'b0,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              rd_acc;
  logic              wr_acc;

  // Flags decode only the registered count, so wr_en/rd_en never reach them combinationally.
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_empty = (count <= AE_C);
  assign almost_full  = (count >= AF_C);

  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      if (rd_acc)
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      if (wr_acc && !rd_acc)
        count <= count + CW'(1);
      else if (rd_acc && !wr_acc)
        count <= count - CW'(1);
      if (wr_en && !wr_acc)
        overflow <= 1'b1;
      if (rd_en && !rd_acc)
        underflow <= 1'b1;
    end
  end

  // Storage is not reset; when full with a simultaneous read, the read sees the old entry.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc)
      mem[wr_ptr] <= wr_data;
  end

  generate
    if (FWFT) begin : g_fwft
      // Head is masked to zero while empty so stale or uninitialised storage never shows.
      assign rd_data  = empty ? '0 : mem[rd_ptr];
      assign rd_valid = !empty;
    end else begin : g_std
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_acc;
          if (rd_acc)
            rd_data <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench: a 64-deep standard-read FIFO and a 5-deep FWFT FIFO, directed stimulus.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: DEPTH=64, standard read
  logic       a_rst, a_wr_en, a_rd_en;
  logic [7:0] a_wr_data, a_rd_data;
  logic       a_rd_valid, a_empty, a_full, a_ae, a_af, a_ovf, a_udf;
  logic [6:0] a_count;

  sync_fifo_param #(.DATA_W(8), .DEPTH(64), .AF_THRESH(56), .AE_THRESH(8), .FWFT(1'b0)) u_a (
    .clk(clk), .rst(a_rst), .wr_en(a_wr_en), .wr_data(a_wr_data), .rd_en(a_rd_en),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .count(a_count), .empty(a_empty),
    .full(a_full), .almost_empty(a_ae), .almost_full(a_af), .overflow(a_ovf), .underflow(a_udf)
  );

  // Instance B: DEPTH=5, FWFT
  logic       b_rst, b_wr_en, b_rd_en;
  logic [7:0] b_wr_data, b_rd_data;
  logic       b_rd_valid, b_empty, b_full, b_ae, b_af, b_ovf, b_udf;
  logic [2:0] b_count;

  sync_fifo_param #(.DATA_W(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1'b1)) u_b (
    .clk(clk), .rst(b_rst), .wr_en(b_wr_en), .wr_data(b_wr_data), .rd_en(b_rd_en),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .count(b_count), .empty(b_empty),
    .full(b_full), .almost_empty(b_ae), .almost_full(b_af), .overflow(b_ovf), .underflow(b_udf)
  );

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors sample on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    logic [7:0] e;
    if (a_rd_valid === 1'b1) begin
      if (exp_a.size() == 0) begin
        chk("a_unexpected_rd_valid", 32'(a_rd_valid), 32'd0);
      end else begin
        e = exp_a.pop_front();
        chk("a_rd_data", 32'(a_rd_data), 32'(e));
      end
    end
    if (b_rd_valid === 1'b1) begin
      if (exp_b.size() == 0) begin
        chk("b_unexpected_rd_valid", 32'(b_rd_valid), 32'd0);
      end else begin
        chk("b_head", 32'(b_rd_data), 32'(exp_b[0]));
        if (b_rd_en === 1'b1)
          void'(exp_b.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [19:0] wr_seq;
  logic [19:0] rd_seq;
  int          b_cnt_exp[20];

  initial begin
    a_rst = 1'b1; a_wr_en = 1'b0; a_rd_en = 1'b0; a_wr_data = '0;
    b_rst = 1'b1; b_wr_en = 1'b0; b_rd_en = 1'b0; b_wr_data = '0;
    wr_seq = 20'h871CF;
    rd_seq = 20'h79E30;
    b_cnt_exp = '{1, 2, 3, 4, 3, 2, 3, 4, 5, 4, 3, 2, 2, 3, 4, 3, 2, 1, 0, 1};
    tick();
    tick();
    a_rst = 1'b0;
    b_rst = 1'b0;

    chk("a_rst_count", 32'(a_count), 32'd0);
    chk("a_rst_empty", 32'(a_empty), 32'd1);
    chk("a_rst_full", 32'(a_full), 32'd0);
    chk("a_rst_ae", 32'(a_ae), 32'd1);
    chk("a_rst_af", 32'(a_af), 32'd0);
    chk("a_rst_ovf", 32'(a_ovf), 32'd0);
    chk("a_rst_udf", 32'(a_udf), 32'd0);
    chk("a_rst_rd_valid", 32'(a_rd_valid), 32'd0);
    chk("a_rst_rd_data", 32'(a_rd_data), 32'd0);
    chk("b_rst_count", 32'(b_count), 32'd0);
    chk("b_rst_rd_valid", 32'(b_rd_valid), 32'd0);
    chk("b_rst_rd_data", 32'(b_rd_data), 32'd0);

    // Fill 0x01..0x40
    for (int i = 1; i <= 64; i++) begin
      a_wr_en = 1'b1;
      a_wr_data = 8'(i);
      exp_a.push_back(8'(i));
      tick();
      if (i == 8)  chk("a_ae_at_8", 32'(a_ae), 32'd1);
      if (i == 9)  chk("a_ae_at_9", 32'(a_ae), 32'd0);
      if (i == 55) chk("a_af_at_55", 32'(a_af), 32'd0);
      if (i == 56) chk("a_af_at_56", 32'(a_af), 32'd1);
      if (i == 63) chk("a_full_at_63", 32'(a_full), 32'd0);
    end
    a_wr_en = 1'b0;
    chk("a_fill_count", 32'(a_count), 32'd64);
    chk("a_fill_full", 32'(a_full), 32'd1);
    chk("a_fill_ovf", 32'(a_ovf), 32'd0);

    // Write into full FIFO without a read is rejected
    a_wr_en = 1'b1;
    a_wr_data = 8'hAA;
    tick();
    a_wr_en = 1'b0;
    chk("a_ovf_set", 32'(a_ovf), 32'd1);
    chk("a_ovf_count", 32'(a_count), 32'd64);

    // Drain all 64; rd_valid must follow each rd_en by one cycle
    for (int i = 1; i <= 64; i++) begin
      a_rd_en = 1'b1;
      tick();
      chk("a_rd_valid_pulse", 32'(a_rd_valid), 32'd1);
      if (i == 1) chk("a_first_read", 32'(a_rd_data), 32'h01);
    end
    a_rd_en = 1'b0;
    tick();
    chk("a_drain_empty", 32'(a_empty), 32'd1);
    chk("a_drain_count", 32'(a_count), 32'd0);
    chk("a_rd_valid_drop", 32'(a_rd_valid), 32'd0);
    chk("a_drain_udf", 32'(a_udf), 32'd0);

    // Refill, then write+read together while full
    for (int i = 1; i <= 64; i++) begin
      a_wr_en = 1'b1;
      a_wr_data = 8'(i);
      exp_a.push_back(8'(i));
      tick();
    end
    a_wr_en = 1'b1;
    a_rd_en = 1'b1;
    a_wr_data = 8'h55;
    exp_a.push_back(8'h55);
    tick();
    a_wr_en = 1'b0;
    a_rd_en = 1'b0;
    chk("a_pass_count", 32'(a_count), 32'd64);
    chk("a_pass_rd_data", 32'(a_rd_data), 32'h01);
    chk("a_pass_ovf_sticky", 32'(a_ovf), 32'd1);
    for (int i = 1; i <= 64; i++) begin
      a_rd_en = 1'b1;
      tick();
    end
    a_rd_en = 1'b0;
    chk("a_pass_last", 32'(a_rd_data), 32'h55);
    tick();
    chk("a_pass_empty", 32'(a_empty), 32'd1);

    // Empty FIFO: write+read together -> write accepted, read rejected
    chk("a_udf_before", 32'(a_udf), 32'd0);
    a_wr_en = 1'b1;
    a_rd_en = 1'b1;
    a_wr_data = 8'h77;
    exp_a.push_back(8'h77);
    tick();
    a_wr_en = 1'b0;
    a_rd_en = 1'b0;
    chk("a_wr_rd_empty_count", 32'(a_count), 32'd1);
    chk("a_udf_set", 32'(a_udf), 32'd1);
    chk("a_wr_rd_empty_valid", 32'(a_rd_valid), 32'd0);
    a_rd_en = 1'b1;
    tick();
    a_rd_en = 1'b0;
    tick();
    chk("a_after_0x77_empty", 32'(a_empty), 32'd1);

    // Mid-operation reset with wr_en held high
    for (int i = 0; i < 11; i++) begin
      a_wr_en = 1'b1;
      a_wr_data = 8'hC0 + 8'(i);
      if (i == 0) exp_a.push_back(8'hC0);
      tick();
    end
    a_wr_en = 1'b0;
    a_rd_en = 1'b1;
    tick();
    a_rd_en = 1'b0;
    chk("a_pre_rst_count", 32'(a_count), 32'd10);
    chk("a_pre_rst_valid", 32'(a_rd_valid), 32'd1);
    a_rst = 1'b1;
    a_wr_en = 1'b1;
    a_wr_data = 8'hEE;
    tick();
    a_rst = 1'b0;
    a_wr_en = 1'b0;
    chk("a_mid_rst_count", 32'(a_count), 32'd0);
    chk("a_mid_rst_empty", 32'(a_empty), 32'd1);
    chk("a_mid_rst_ae", 32'(a_ae), 32'd1);
    chk("a_mid_rst_af", 32'(a_af), 32'd0);
    chk("a_mid_rst_ovf", 32'(a_ovf), 32'd0);
    chk("a_mid_rst_udf", 32'(a_udf), 32'd0);
    chk("a_mid_rst_valid", 32'(a_rd_valid), 32'd0);
    chk("a_mid_rst_data", 32'(a_rd_data), 32'd0);

    // FWFT, DEPTH=5: 20 interleaved steps, pointers wrap twice
    for (int i = 0; i < 20; i++) begin
      b_wr_en = wr_seq[i];
      b_rd_en = rd_seq[i];
      b_wr_data = 8'h10 + 8'(i);
      if (wr_seq[i]) exp_b.push_back(8'h10 + 8'(i));
      tick();
      chk("b_count", 32'(b_count), 32'(b_cnt_exp[i]));
      if (i == 0) chk("b_fwft_first_visible", 32'(b_rd_data), 32'h10);
      if (i == 8) chk("b_full_at_5", 32'(b_full), 32'd1);
    end
    b_wr_en = 1'b0;
    b_rd_en = 1'b1;
    tick();
    b_rd_en = 1'b0;
    chk("b_drain_empty", 32'(b_empty), 32'd1);
    chk("b_drain_valid", 32'(b_rd_valid), 32'd0);
    chk("b_no_ovf", 32'(b_ovf), 32'd0);
    chk("b_no_udf", 32'(b_udf), 32'd0);

    tick();
    tick();
    chk("a_scoreboard_drained", 32'(exp_a.size()), 32'd0);
    chk("b_scoreboard_drained", 32'(exp_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
